// File: rtl/frame_update_scheduler_if.sv
// frame_update_scheduler_if: frame event, client handshake and status bundle
interface frame_update_scheduler_if #(
  parameter int N = 5,
  parameter int W = 16
);
  logic startOfFrame;
  logic [N-1:0] update_req;
  logic [N-1:0] update_done;
  logic [N-1:0] update_grant;
  logic [W-1:0] frame_count;
  logic busy;
  logic overrun;
  logic timeout;
  modport master (
    output startOfFrame, update_req, update_done,
    input update_grant, frame_count, busy, overrun, timeout
  );
  modport slave (
    input startOfFrame, update_req, update_done,
    output update_grant, frame_count, busy, overrun, timeout
  );
endinterface

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler: per-frame ascending-index grant sweep with per-grant timeout
module frame_update_scheduler #(
  parameter int NUMBER_OF_CLIENTS = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input logic clk,
  input logic resetN,
  frame_update_scheduler_if.slave bus
);
  localparam int N = NUMBER_OF_CLIENTS;
  localparam int W = FRAME_COUNT_WIDTH;
  localparam int IW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;
  state_t state;
  logic sof_d;
  logic [N-1:0] pending;
  logic [N-1:0] grant;
  logic [N-1:0] sel;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic [W-1:0] frame_count;
  logic busy;
  logic overrun;
  logic timeout;
  logic ev;
  logic hit;
  logic done;
  logic expired;
  assign sel = N'(1) << idx;
  assign ev = bus.startOfFrame & ~sof_d;
  assign hit = |(pending & sel);
  assign done = |(bus.update_done & sel);
  assign expired = timer == TW'(TIMEOUT_CYCLES - 1);
  assign bus.update_grant = grant;
  assign bus.frame_count = frame_count;
  assign bus.busy = busy;
  assign bus.overrun = overrun;
  assign bus.timeout = timeout;
  // Edge-detect the frame strobe, count frames, and walk the latched requests one client at a time
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      sof_d <= 1'b0;
      pending <= '0;
      grant <= '0;
      idx <= '0;
      timer <= '0;
      frame_count <= '0;
      busy <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      sof_d <= bus.startOfFrame;
      overrun <= ev && state != IDLE;
      timeout <= 1'b0;
      if (ev) frame_count <= frame_count + W'(1);
      case (state)
        IDLE: if (ev) begin
          pending <= bus.update_req;
          idx <= '0;
          state <= SCAN;
          busy <= 1'b1;
        end
        SCAN: if (idx == IW'(N)) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (hit) begin
          state <= GRANT;
          timer <= '0;
          grant <= sel;
        end else begin
          idx <= idx + IW'(1);
        end
        GRANT: if (done || expired) begin
          grant <= '0;
          pending <= pending & ~sel;
          idx <= idx + IW'(1);
          state <= SCAN;
          timeout <= !done;
        end else begin
          timer <= timer + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
